instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 13 +
 rtl/instr_fetch_if.sv | 16 +
 rtl/instr_fetch_if_id_reg.sv | 42 ++++
 rtl/instr_fetch.sv | 91 +++++++++
 tb/tb_instr_fetch.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } if_state_e;

  localparam int          IW_DEF       = 16;
  localparam logic [15:0] NOP_WORD_DEF = 16'h0000;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory port: fetch stage is master, memory is slave.
interface instr_fetch_if
  import instr_fetch_pkg::*;
#(
  parameter int IW = IW_DEF
);
  logic          imem_req;
  logic [7:0]    imem_addr;
  logic          imem_ready;
  logic [IW-1:0] imem_data;

  modport master (output imem_req, output imem_addr,
                  input  imem_ready, input imem_data);
  modport slave  (input  imem_req, input imem_addr,
                  output imem_ready, output imem_data);
endinterface

// File: rtl/instr_fetch_if_id_reg.sv
// IF/ID pipeline register: instruction word, its PC and a valid flag.
// Flush inserts a bubble and wins over load; otherwise everything holds.
module if_id_reg #(
  parameter int            IW       = 16,
  parameter logic [IW-1:0] NOP_WORD = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic          i_flush,
  input  logic [7:0]    i_pc,
  input  logic [IW-1:0] i_ir,
  output logic [IW-1:0] o_ir,
  output logic          o_ir_valid,
  output logic [7:0]    o_pc_minus1
);

  logic [IW-1:0] r_ir;
  logic          r_ir_valid;
  logic [7:0]    r_pc_minus1;

  // Bubble on flush (PC of the held slot is kept), capture on load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir        <= NOP_WORD;
      r_ir_valid  <= 1'b0;
      r_pc_minus1 <= 8'h00;
    end else if (i_flush) begin
      r_ir        <= NOP_WORD;
      r_ir_valid  <= 1'b0;
    end else if (i_load) begin
      r_ir        <= i_ir;
      r_ir_valid  <= 1'b1;
      r_pc_minus1 <= i_pc;
    end
  end

  assign o_ir        = r_ir;
  assign o_ir_valid  = r_ir_valid;
  assign o_pc_minus1 = r_pc_minus1;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: IDLE/FETCH/HOLD control, PC register and the
// IF/ID register. The next PC always comes from outside (no local +1).
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [7:0]    RESET_PC = 8'h00,
  parameter int            IW       = IW_DEF,
  parameter logic [IW-1:0] NOP_WORD = IW'(NOP_WORD_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       pc_next,
  input  logic             redirect,
  input  logic             stall,
  instr_fetch_if.master    imem,
  output logic [7:0]       pc,
  output logic [7:0]       pc_minus1,
  output logic [IW-1:0]    ir,
  output logic             ir_valid
);

  if_state_e  r_state, w_state_nxt;
  logic [7:0] r_pc;
  logic       w_pc_load;
  logic       w_ir_load;
  logic       w_ir_flush;

  // State register; reset drops any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and register controls: redirect > stall > capture.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_load   = 1'b0;
    w_ir_load   = 1'b0;
    w_ir_flush  = 1'b0;
    case (r_state)
      IDLE: w_state_nxt = FETCH;
      FETCH: begin
        if (redirect) begin
          w_pc_load  = 1'b1;
          w_ir_flush = 1'b1;
        end else if (stall) begin
          w_state_nxt = HOLD;
        end else if (imem.imem_ready) begin
          w_pc_load = 1'b1;
          w_ir_load = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          w_pc_load   = 1'b1;
          w_ir_flush  = 1'b1;
          w_state_nxt = FETCH;
        end else if (!stall) begin
          w_state_nxt = FETCH;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // PC register: loads the externally selected next PC unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_pc <= RESET_PC;
    else if (w_pc_load) r_pc <= pc_next;
  end

  if_id_reg #(
    .IW       (IW),
    .NOP_WORD (NOP_WORD)
  ) u_if_id_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_ir_load),
    .i_flush     (w_ir_flush),
    .i_pc        (r_pc),
    .i_ir        (imem.imem_data),
    .o_ir        (ir),
    .o_ir_valid  (ir_valid),
    .o_pc_minus1 (pc_minus1)
  );

  assign imem.imem_req  = (r_state == FETCH);
  assign imem.imem_addr = r_pc;
  assign pc             = r_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  pc_next = 8'h01;
  logic        redirect = 1'b0;
  logic        stall = 1'b0;
  logic [7:0]  pc, pc_minus1;
  logic [15:0] ir;
  logic        ir_valid;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  instr_fetch_if #(.IW(16)) u_if ();

  instr_fetch #(.RESET_PC(8'h00), .IW(16), .NOP_WORD(16'h0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc_next   (pc_next),
    .redirect  (redirect),
    .stall     (stall),
    .imem      (u_if),
    .pc        (pc),
    .pc_minus1 (pc_minus1),
    .ir        (ir),
    .ir_valid  (ir_valid)
  );

  always #5 clk = ~clk;

  // Behavioural model. mode: 0 = waking up after reset, 1 = requesting,
  // 2 = parked on a stall.
  int          m_mode;
  logic [7:0]  m_pc, m_pcm1;
  logic [15:0] m_ir;
  logic        m_v;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0; m_pc <= 8'h00; m_pcm1 <= 8'h00; m_ir <= 16'h0000; m_v <= 1'b0;
    end else if (m_mode == 0) begin
      m_mode <= 1;
    end else if (redirect) begin
      m_pc <= pc_next; m_ir <= 16'h0000; m_v <= 1'b0; m_mode <= 1;
    end else if (stall) begin
      m_mode <= 2;
    end else if (m_mode == 2) begin
      m_mode <= 1;
    end else if (u_if.imem_ready) begin
      m_ir <= u_if.imem_data; m_v <= 1'b1; m_pcm1 <= m_pc; m_pc <= pc_next;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_pc",        32'(pc),               32'(m_pc));
      chk("m_addr",      32'(u_if.imem_addr),   32'(m_pc));
      chk("m_pcm1",      32'(pc_minus1),        32'(m_pcm1));
      chk("m_ir",        32'(ir),               32'(m_ir));
      chk("m_ir_valid",  32'(ir_valid),         32'(m_v));
      chk("m_imem_req",  32'(u_if.imem_req),    32'(m_mode == 1));
    end
  end

  task automatic step(input bit rdy, input logic [15:0] d, input logic [7:0] pn,
                      input bit st, input bit rd);
    #1;
    u_if.imem_ready = rdy; u_if.imem_data = d; pc_next = pn; stall = st; redirect = rd;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    u_if.imem_ready = 1'b1;
    u_if.imem_data  = 16'h1234;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_pc", 32'(pc), 32'h00);
    chk("rst_pcm1", 32'(pc_minus1), 32'h00);
    chk("rst_ir", 32'(ir), 32'h0000);
    chk("rst_valid", 32'(ir_valid), 32'h0);
    chk("rst_req", 32'(u_if.imem_req), 32'h0);

    // Startup: edge 1 leaves IDLE, edge 2 captures.
    #1 rst_n = 1'b1;
    chk("idle_req", 32'(u_if.imem_req), 32'h0);
    @(posedge clk); @(negedge clk);
    chk("e1_req", 32'(u_if.imem_req), 32'h1);
    chk("e1_valid", 32'(ir_valid), 32'h0);
    step(1, 16'h1234, 8'h01, 0, 0);
    chk("e2_ir", 32'(ir), 32'h1234);
    chk("e2_valid", 32'(ir_valid), 32'h1);
    chk("e2_pc", 32'(pc), 32'h01);
    chk("e2_pcm1", 32'(pc_minus1), 32'h00);

    // Wait states at pc 05.
    step(1, 16'h1111, 8'h05, 0, 0);
    chk("ws_pc0", 32'(pc), 32'h05);
    for (int i = 0; i < 3; i++) begin
      step(0, 16'h2222, 8'h06, 0, 0);
      chk("ws_pc", 32'(pc), 32'h05);
      chk("ws_ir", 32'(ir), 32'h1111);
      chk("ws_req", 32'(u_if.imem_req), 32'h1);
    end
    step(1, 16'h3333, 8'h06, 0, 0);
    chk("ws_ir_rdy", 32'(ir), 32'h3333);
    chk("ws_pcm1", 32'(pc_minus1), 32'h05);

    // Stall for two cycles.
    step(1, 16'hABCD, 8'h07, 0, 0);
    for (int i = 0; i < 2; i++) begin
      step(1, 16'h5555, 8'h08, 1, 0);
      chk("st_req", 32'(u_if.imem_req), 32'h0);
      chk("st_ir", 32'(ir), 32'hABCD);
      chk("st_pc", 32'(pc), 32'h07);
    end
    step(1, 16'h6666, 8'h08, 0, 0);
    chk("st_back_req", 32'(u_if.imem_req), 32'h1);
    chk("st_back_ir", 32'(ir), 32'hABCD);
    step(1, 16'h6666, 8'h08, 0, 0);
    chk("st_cap_ir", 32'(ir), 32'h6666);
    chk("st_cap_pcm1", 32'(pc_minus1), 32'h07);

    // Redirect at pc 10.
    step(1, 16'h7777, 8'h10, 0, 0);
    step(1, 16'h8888, 8'h40, 0, 1);
    chk("rd_pc", 32'(pc), 32'h40);
    chk("rd_ir", 32'(ir), 32'h0000);
    chk("rd_valid", 32'(ir_valid), 32'h0);
    chk("rd_pcm1", 32'(pc_minus1), 32'h08);
    step(1, 16'h9999, 8'h41, 0, 0);
    chk("rd_next_pcm1", 32'(pc_minus1), 32'h40);
    chk("rd_next_ir", 32'(ir), 32'h9999);

    // Redirect + stall together, then wrap.
    step(1, 16'hAAAA, 8'hFF, 1, 1);
    chk("col_req", 32'(u_if.imem_req), 32'h1);
    chk("col_pc", 32'(pc), 32'hFF);
    chk("col_valid", 32'(ir_valid), 32'h0);
    step(1, 16'hBBBB, 8'h00, 0, 0);
    chk("wrap_pc", 32'(pc), 32'h00);
    chk("wrap_pcm1", 32'(pc_minus1), 32'hFF);

    // Async reset while parked in HOLD.
    step(1, 16'hCCCC, 8'h01, 1, 0);
    chk("h_req", 32'(u_if.imem_req), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_pc", 32'(pc), 32'h00);
    chk("ar_pcm1", 32'(pc_minus1), 32'h00);
    chk("ar_ir", 32'(ir), 32'h0000);
    chk("ar_valid", 32'(ir_valid), 32'h0);
    chk("ar_req", 32'(u_if.imem_req), 32'h0);
    @(posedge clk); @(negedge clk);
    #1 rst_n = 1'b1; stall = 1'b0;

    // Randomized traffic with occasional reset pulses.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(149) == 0) begin
        #1 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
      end else begin
        step($urandom_range(2) != 0, 16'($urandom), 8'($urandom),
             $urandom_range(4) == 0, $urandom_range(7) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
